seg_scan_pwm: RTL and testbench

- Parametrised successor to the fixed 8-digit seven-segment scanner: time-multiplexes N_DIGITS digit patterns onto one shared segment bus.
- Adds per-digit PWM brightness, dead-time (anti-ghosting) blanking, per-digit blank and blink masks, and frame-coherent input snapshotting.
- Sits between the Morse decode/display formatter (which drives packed segment patterns) and the board digit-enable and segment pins.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_scan_timer.sv | 71 +++++++
 rtl/seg_scan_pwm.sv | 123 ++++++++++++
 tb/tb_seg_scan_pwm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Purpose: shared constants and helpers for the multiplexed seven-segment scanner.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    // Widest digit count the helpers cover; per-instance vectors are sliced down.
    localparam int MAX_DIGITS = 16;

    // Segment bus value that lights nothing, before polarity is applied.
    localparam logic [7:0] SEG_OFF = 8'h00;

    // PWM steps in one digit slot: dead-time steps followed by the brightness steps.
    function automatic int slot_len(input int bright_w, input int dead);
        return (1 << bright_w) + dead;
    endfunction

    // Index to one-hot digit-enable vector (logical, active-high form).
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Logical enables to pin polarity.
    function automatic logic [MAX_DIGITS-1:0] en_polarity(input logic [MAX_DIGITS-1:0] en,
                                                          input logic active_low);
        return active_low ? ~en : en;
    endfunction

    // Logical segment pattern to pin polarity.
    function automatic logic [7:0] seg_polarity(input logic [7:0] seg, input logic invert);
        return invert ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Purpose: free-running scan timebase: prescaler p, slot step s, digit d, blink phase.
// Latency: counters registered; frame_start/frame_wrap decoded from the current counter state.
// Backpressure: none, free-running.
// Ports: clk_fast/rst (sync, active-low); d, s current digit/step; frame_start when p=s=d=0;
//        frame_wrap in the last cycle of a frame; blink_phase 1 = blinking digits dark.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4,
    parameter int PRESCALE = 16,
    parameter int DEAD     = 1,
    parameter int BLINK_W  = 6,
    localparam int SLOT    = slot_len(BRIGHT_W, DEAD),
    localparam int S_W     = $clog2(SLOT),
    localparam int D_W     = $clog2(N_DIGITS)
) (
    input  logic           clk_fast,
    input  logic           rst,
    output logic [D_W-1:0] d,
    output logic [S_W-1:0] s,
    output logic           frame_start,
    output logic           frame_wrap,
    output logic           blink_phase
);

    localparam int P_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [P_W-1:0]     p;
    logic [BLINK_W-1:0] blink_cnt;
    logic               p_max;
    logic               s_max;
    logic               d_max;

    assign p_max       = (p == P_W'(PRESCALE - 1));
    assign s_max       = (s == S_W'(SLOT - 1));
    assign d_max       = (d == D_W'(N_DIGITS - 1));
    assign frame_wrap  = p_max && s_max && d_max;
    assign frame_start = (p == '0) && (s == '0) && (d == '0);

    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            p           <= '0;
            s           <= '0;
            d           <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (p_max) begin
                p <= '0;
                if (s_max) begin
                    s <= '0;
                    d <= d_max ? '0 : d + D_W'(1);
                end else begin
                    s <= s + S_W'(1);
                end
            end else begin
                p <= p + P_W'(1);
            end

            // Blink phase flips every 2**BLINK_W frames.
            if (frame_wrap) begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
                if (&blink_cnt) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_pwm.sv
// Purpose: time-multiplexed N-digit seven-segment driver with PWM brightness, dead time, blank/blink.
// Latency: outputs registered, one cycle after the counter state; inputs take effect at next frame start.
// Backpressure: none; inputs are snapshotted once per frame.
// Ports: clk_fast/rst (sync, active-low); seg_in packed patterns (digit k = [8k+7:8k]);
//        blank_mask/blink_mask per digit; bright lit steps per slot;
//        seg_en digit enables, seg_out segments, frame_tick one-cycle pulse per frame.
module seg_scan_pwm
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int BRIGHT_W      = 4,
    parameter int PRESCALE      = 16,
    parameter int DEAD          = 1,
    parameter int BLINK_W       = 6,
    parameter int EN_ACTIVE_LOW = 1,
    parameter int SEG_INVERT    = 0
) (
    input  logic                  clk_fast,
    input  logic                  rst,
    input  logic [8*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIGITS-1:0]   seg_en,
    output logic [7:0]            seg_out,
    output logic                  frame_tick
);

    localparam int SLOT = slot_len(BRIGHT_W, DEAD);
    localparam int S_W  = $clog2(SLOT);
    localparam int D_W  = $clog2(N_DIGITS);
    localparam logic EN_LOW  = (EN_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_INVERT != 0);

    // Dead time is what separates adjacent digits and hides the shadow reload, so it is mandatory.
    generate
        if (N_DIGITS < 2 || N_DIGITS > MAX_DIGITS || DEAD < 1 || PRESCALE < 1 ||
            BRIGHT_W < 1 || BLINK_W < 1) begin : g_bad_params
            $error("seg_scan_pwm: illegal parameter set");
        end
    endgenerate

    logic [D_W-1:0] d;
    logic [S_W-1:0] s;
    logic           frame_start;
    logic           frame_wrap;
    logic           blink_phase;

    seg_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .BRIGHT_W (BRIGHT_W),
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD),
        .BLINK_W  (BLINK_W)
    ) u_timer (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .d           (d),
        .s           (s),
        .frame_start (frame_start),
        .frame_wrap  (frame_wrap),
        .blink_phase (blink_phase)
    );

    // Frame-coherent copies of the inputs; the display reads only these.
    logic [8*N_DIGITS-1:0] seg_sh;
    logic [N_DIGITS-1:0]   blank_sh;
    logic [N_DIGITS-1:0]   blink_sh;
    logic [BRIGHT_W-1:0]   bright_sh;

    logic [7:0] pat;
    logic       blank_d;
    logic       blink_d;
    logic       in_window;
    logic       lit;

    always_comb begin
        pat     = SEG_OFF;
        blank_d = 1'b0;
        blink_d = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (d == D_W'(k)) begin
                pat     = seg_sh[8*k +: 8];
                blank_d = blank_sh[k];
                blink_d = blink_sh[k];
            end
        end
        // Lit window: steps DEAD .. DEAD+bright-1 of the slot.
        in_window = (s >= S_W'(DEAD)) &&
                    ((s - S_W'(DEAD)) < {{(S_W-BRIGHT_W){1'b0}}, bright_sh});
        lit = in_window && !blank_d && !(blink_d && blink_phase);
    end

    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            seg_sh     <= '0;
            blank_sh   <= '0;
            blink_sh   <= '0;
            bright_sh  <= '0;
            seg_en     <= N_DIGITS'(en_polarity('0, EN_LOW));
            seg_out    <= seg_polarity(SEG_OFF, SEG_INV);
            frame_tick <= 1'b0;
        end else begin
            // Reload at frame start is safe: step 0 is always dead, so the old
            // shadows never reach the pins in the same cycle.
            if (frame_start) begin
                seg_sh    <= seg_in;
                blank_sh  <= blank_mask;
                blink_sh  <= blink_mask;
                bright_sh <= bright;
            end
            frame_tick <= frame_wrap;
            if (lit) begin
                seg_en  <= N_DIGITS'(en_polarity(onehot(4'(d)), EN_LOW));
                seg_out <= seg_polarity(pat, SEG_INV);
            end else begin
                seg_en  <= N_DIGITS'(en_polarity('0, EN_LOW));
                seg_out <= seg_polarity(SEG_OFF, SEG_INV);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_pwm.sv
// Purpose: self-checking bench for seg_scan_pwm (default and inverted-polarity instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_pwm;

    localparam int N        = 8;
    localparam int BW       = 4;
    localparam int PRE      = 16;
    localparam int DEADS    = 1;
    localparam int BLW      = 1;
    localparam int SLOT_CYC = ((1 << BW) + DEADS) * PRE;
    localparam int FRAME    = N * SLOT_CYC;

    logic          clk_fast = 1'b0;
    logic          rst = 1'b0;
    logic [63:0]   seg_in = '0;
    logic [7:0]    blank_mask = '0;
    logic [7:0]    blink_mask = '0;
    logic [3:0]    bright = '0;
    logic [7:0]    seg_en, seg_out, pen, pout;
    logic          tick, ptick;

    always #5 clk_fast = ~clk_fast;

    seg_scan_pwm #(.N_DIGITS(N), .BRIGHT_W(BW), .PRESCALE(PRE), .DEAD(DEADS), .BLINK_W(BLW),
                   .EN_ACTIVE_LOW(1), .SEG_INVERT(0)) u_dut (
        .clk_fast(clk_fast), .rst(rst), .seg_in(seg_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .bright(bright), .seg_en(seg_en), .seg_out(seg_out),
        .frame_tick(tick));

    seg_scan_pwm #(.N_DIGITS(N), .BRIGHT_W(BW), .PRESCALE(PRE), .DEAD(DEADS), .BLINK_W(BLW),
                   .EN_ACTIVE_LOW(0), .SEG_INVERT(1)) u_pol (
        .clk_fast(clk_fast), .rst(rst), .seg_in(seg_in), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .bright(bright), .seg_en(pen), .seg_out(pout),
        .frame_tick(ptick));

    int total = 0;
    int bad   = 0;
    int k     = 0;   // index of the next clock edge since reset release

    // Reference snapshot of the inputs taken at each frame start.
    logic [63:0] sn_seg;
    logic [7:0]  sn_blank, sn_blink;
    logic [3:0]  sn_bright;

    typedef struct {
        logic [63:0] seg;
        logic [7:0]  blank;
        logic [3:0]  bright;
        logic [7:0]  lit_dig;
        int          lit_n;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // Expected state for cycle kk from absolute timing arithmetic.
    task automatic model(input int kk, output logic lit, output int slot, output logic tick_e);
        int o, f, stp;
        o    = kk % FRAME;
        f    = kk / FRAME;
        slot = o / SLOT_CYC;
        stp  = (o % SLOT_CYC) / PRE;
        lit  = (stp >= DEADS) && ((stp - DEADS) < int'(sn_bright)) && !sn_blank[slot] &&
               !(sn_blink[slot] && (((f >> BLW) & 1) == 1));
        tick_e = ((kk + 1) % FRAME == 0);
    endtask

    task automatic step();
        logic lit, te;
        int slot;
        logic [7:0] pat, e_en, e_out, e_pen, e_pout;
        if (k % FRAME == 0) begin
            sn_seg = seg_in; sn_blank = blank_mask; sn_blink = blink_mask; sn_bright = bright;
        end
        model(k, lit, slot, te);
        pat    = sn_seg[8*slot +: 8];
        e_en   = lit ? ~(8'd1 << slot) : 8'hFF;
        e_out  = lit ? pat : 8'h00;
        e_pen  = lit ? (8'd1 << slot) : 8'h00;
        e_pout = lit ? ~pat : 8'hFF;
        @(posedge clk_fast);
        #1;
        chk("scan", k, {tick, seg_en, seg_out}, {te, e_en, e_out});
        chk("pol", k, {ptick, pen, pout}, {te, e_pen, e_pout});
        k++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) begin
            @(posedge clk_fast);
            #1;
            chk("rst_en", k, seg_en, 8'hFF);
            chk("rst_out", k, seg_out, 8'h00);
            chk("rst_tick", k, tick, 0);
            chk("rst_pol", k, {pen, pout, ptick}, {8'h00, 8'hFF, 1'b0});
        end
        rst = 1'b1;
        k = 0;
    endtask

    task automatic first_tick();
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < FRAME + 10) begin
            step();
            n++;
            if (tick) seen = 1'b1;
        end
        chk("first_tick_latency", k, n, FRAME);
    endtask

    task automatic run_to_start();
        while (k % FRAME != 0) step();
    endtask

    function automatic int digit_of(input logic [7:0] en);
        int r;
        r = -1;
        for (int j = 0; j < 8; j++) if (en[j] == 1'b0) r = j;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pa, pb;
        int cnt[8];
        int dg, mism, hits;

        tbl[0] = '{64'h0807060504030201, 8'h00, 4'd15, 8'hFF, 240};
        tbl[1] = '{64'h0807060504030201, 8'h00, 4'd4,  8'hFF, 64};
        tbl[2] = '{64'h0807060504030201, 8'h00, 4'd0,  8'h00, 0};
        tbl[3] = '{64'h0807060504030201, 8'h02, 4'd15, 8'hFD, 240};
        tbl[4] = '{64'h1122334455667788, 8'hA5, 4'd8,  8'h5A, 128};

        // Reset from power-up, then first frame with all-zero inputs (bright=0: dark).
        do_reset(3);
        first_tick();

        // Table: one full frame per vector, lit cycles counted per digit.
        for (int i = 0; i < 5; i++) begin
            seg_in = tbl[i].seg; blank_mask = tbl[i].blank; blink_mask = 8'h00;
            bright = tbl[i].bright;
            run_to_start();
            for (int j = 0; j < 8; j++) cnt[j] = 0;
            repeat (FRAME) begin
                step();
                dg = digit_of(seg_en);
                if (dg >= 0) cnt[dg]++;
            end
            for (int j = 0; j < 8; j++)
                chk("tbl_lit", i * 8 + j, cnt[j], tbl[i].lit_dig[j] ? tbl[i].lit_n : 0);
        end

        // Blink: digit 0 lit 2 frames, dark 2 frames.
        seg_in = 64'h0807060504030201; bright = 4'd15; blank_mask = 8'h00; blink_mask = 8'h01;
        while (k % (4 * FRAME) != 0) step();
        for (int fr = 0; fr < 4; fr++) begin
            cnt[0] = 0;
            repeat (FRAME) begin
                step();
                if (digit_of(seg_en) == 0) cnt[0]++;
            end
            chk("blink", fr, cnt[0], (fr < 2) ? 240 : 0);
        end

        // Coherence: mid-frame change is invisible until the next frame.
        pa = 64'h8877665544332211;
        pb = 64'h0F1E2D3C4B5A6978;
        blink_mask = 8'h00; seg_in = pa;
        run_to_start();
        repeat (1000) step();
        seg_in = pb;
        mism = 0;
        while (k % FRAME != 0) begin
            step();
            dg = digit_of(seg_en);
            if (dg >= 0 && seg_out != pa[8*dg +: 8]) mism++;
        end
        chk("coherent_old", k, mism, 0);
        hits = 0;
        repeat (FRAME) begin
            step();
            dg = digit_of(seg_en);
            if (dg >= 0 && seg_out == pb[8*dg +: 8]) hits++;
        end
        chk("coherent_new", k, hits, 8 * 240);

        // Random inputs, changed at random instants, checked every cycle by the model.
        repeat (4 * FRAME) begin
            if ($urandom_range(0, 399) == 0) begin
                seg_in     = {$urandom, $urandom};
                blank_mask = 8'($urandom_range(0, 255));
                blink_mask = 8'($urandom_range(0, 255));
                bright     = 4'($urandom_range(0, 15));
            end
            step();
        end

        // Reset mid-frame aborts the frame; timing restarts from zero.
        seg_in = 64'h0807060504030201; bright = 4'd15; blank_mask = 8'h00; blink_mask = 8'h00;
        run_to_start();
        repeat (700) step();
        do_reset(3);
        first_tick();
        repeat (SLOT_CYC * 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
